// File: rtl/quad_step_decoder_if.sv
// Bundle of the quadrature decoder's signals, excluding clock and reset.
// master: drives a_in/b_in/en/clr_err and observes the decoder outputs.
// slave : the decoder side; ports: ready, step, dir, err_pulse, err_cnt[ERR_W], ab_state[2].
interface quad_step_decoder_if #(
  parameter int ERR_W = 8
);
  logic             a_in;
  logic             b_in;
  logic             en;
  logic             clr_err;
  logic             ready;
  logic             step;
  logic             dir;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       ab_state;

  modport master (
    output a_in, b_in, en, clr_err,
    input  ready, step, dir, err_pulse, err_cnt, ab_state
  );

  modport slave (
    input  a_in, b_in, en, clr_err,
    output ready, step, dir, err_pulse, err_cnt, ab_state
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Synchronises, glitch-filters and decodes two quadrature inputs into a step pulse + direction.
// Latency: step/err_pulse high the cycle after edge FILT_LEN+2 (edge 0 = first sample of a change).
// No backpressure: step is a one-cycle pulse. Ports: clk, rst (async, high), bus (slave modport).
module quad_step_decoder #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 3,
  parameter int ERR_W    = 8
) (
  input logic                clk,
  input logic                rst,
  quad_step_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] FILT_TOP   = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] INIT_EDGES = CNT_W'(FILT_LEN + 2);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                sync1_q, sync1_d;
  logic [1:0]                sync2_q, sync2_d;
  logic [1:0]                filt_q, filt_d;
  logic [1:0]                prev_q, prev_d;
  logic [1:0][CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]          init_cnt_q, init_cnt_d;
  logic                      ready_q, ready_d;
  logic                      step_q, step_d;
  logic                      dir_q, dir_d;
  logic                      err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]          err_cnt_q, err_cnt_d;
  logic [1:0]                diff;
  logic                      fwd;

  always_comb begin
    sync1_d     = {bus.a_in, bus.b_in};
    sync2_d     = sync1_q;
    filt_d      = filt_q;
    fcnt_d      = fcnt_q;
    prev_d      = filt_q;  // prev follows cur every edge, even with en low
    init_cnt_d  = init_cnt_q;
    state_d     = state_q;
    ready_d     = ready_q;
    step_d      = 1'b0;
    dir_d       = dir_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    diff = prev_q ^ filt_q;
    // For a single-bit change, A_new != B_old exactly on the forward
    // sequence 00->10->11->01->00.
    fwd  = prev_q[0] ^ filt_q[1];

    if (state_q == ST_INIT) begin
      // Track the inputs unfiltered so a resting non-00 encoder is
      // adopted as the starting state instead of being seen as a move.
      filt_d     = sync2_q;
      fcnt_d     = '0;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_d == INIT_EDGES) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2_q[ch] != filt_q[ch]) begin
          if (fcnt_q[ch] == FILT_TOP) begin
            filt_d[ch] = sync2_q[ch];
            fcnt_d[ch] = '0;
          end else begin
            fcnt_d[ch] = fcnt_q[ch] + 1'b1;
          end
        end else begin
          fcnt_d[ch] = '0;
        end
      end

      if (bus.en) begin
        if (diff == 2'b11) begin
          err_pulse_d = 1'b1;
        end else if (diff != 2'b00) begin
          step_d = 1'b1;
          dir_d  = fwd;
        end
      end
    end

    // A clear coincident with an error leaves that error counted.
    if (bus.clr_err) begin
      err_cnt_d = {{(ERR_W-1){1'b0}}, err_pulse_d};
    end else if (err_pulse_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      filt_q      <= 2'b00;
      prev_q      <= 2'b00;
      fcnt_q      <= '0;
      init_cnt_q  <= '0;
      ready_q     <= 1'b0;
      step_q      <= 1'b0;
      dir_q       <= 1'b1;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      prev_q      <= prev_d;
      fcnt_q      <= fcnt_d;
      init_cnt_q  <= init_cnt_d;
      ready_q     <= ready_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.ab_state  = filt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed plan scenarios followed by random
// encoder activity, every cycle compared with a behavioural model.
// Two instances (ERR_W=8 and ERR_W=2) share stimulus to cover err_cnt saturation.
module tb_quad_step_decoder;
  localparam int FILT_LEN = 4;

  logic clk;
  logic rst;
  logic a_in, b_in, en, clr_err;

  quad_step_decoder_if #(.ERR_W(8)) bus8 ();
  quad_step_decoder_if #(.ERR_W(2)) bus2 ();

  assign bus8.a_in = a_in;  assign bus8.b_in = b_in;
  assign bus8.en = en;      assign bus8.clr_err = clr_err;
  assign bus2.a_in = a_in;  assign bus2.b_in = b_in;
  assign bus2.en = en;      assign bus2.clr_err = clr_err;

  quad_step_decoder #(.FILT_LEN(FILT_LEN), .CNT_W(3), .ERR_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  quad_step_decoder #(.FILT_LEN(FILT_LEN), .CNT_W(3), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int n_steps  = 0;
  int n_errp   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] m_s1, m_s2, m_filt, m_prev;
  int         m_run [2];
  int         m_edges;
  bit         m_running;
  bit         m_ready, m_step, m_dir, m_errp;
  int         m_errs;  // unbounded; each width saturates it separately

  // Position along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic int gpos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 2'b00; m_s2 = 2'b00; m_filt = 2'b00; m_prev = 2'b00;
    m_run[0] = 0; m_run[1] = 0; m_edges = 0; m_running = 0;
    m_ready = 0; m_step = 0; m_dir = 1; m_errp = 0; m_errs = 0;
  endtask

  task automatic model_edge();
    logic [1:0] nf;
    int d;
    if (rst) return;
    nf = m_filt;
    if (!m_running) begin
      nf = m_s2;
      m_run[0] = 0; m_run[1] = 0;
      m_step = 0; m_errp = 0;
      m_edges++;
      if (m_edges == FILT_LEN + 2) begin
        m_running = 1;
        m_ready   = 1;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_s2[c] != m_filt[c]) begin
          m_run[c]++;
          if (m_run[c] == FILT_LEN) begin
            nf[c] = m_s2[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      d = (gpos(m_filt) - gpos(m_prev) + 4) % 4;
      m_step = en && (d == 1 || d == 3);
      m_errp = en && (d == 2);
      if (m_step) m_dir = (d == 1);
    end
    if (clr_err) m_errs = m_errp ? 1 : 0;
    else if (m_errp) m_errs++;
    m_prev = m_filt;
    m_filt = nf;
    m_s2   = m_s1;
    m_s1   = {a_in, b_in};
  endtask

  task automatic compare(input string tag);
    check({tag, ".ready"},     32'(bus8.ready),     32'(m_ready));
    check({tag, ".step"},      32'(bus8.step),      32'(m_step));
    check({tag, ".dir"},       32'(bus8.dir),       32'(m_dir));
    check({tag, ".err_pulse"}, 32'(bus8.err_pulse), 32'(m_errp));
    check({tag, ".ab_state"},  32'(bus8.ab_state),  32'(m_filt));
    check({tag, ".err_cnt8"},  32'(bus8.err_cnt),   32'((m_errs > 255) ? 255 : m_errs));
    check({tag, ".err_cnt2"},  32'(bus2.err_cnt),   32'((m_errs > 3) ? 3 : m_errs));
    check({tag, ".step2"},     32'(bus2.step),      32'(m_step));
  endtask

  // One clock: model advances at the edge, outputs checked at the negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare("cyc");
    if (bus8.step) n_steps++;
    if (bus8.err_pulse) n_errp++;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    {a_in, b_in} = ab;
    hold(n);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    compare("rst");
    hold(cycles);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] fwd_seq [4];
    logic [1:0] rev_seq [4];
    logic       dir_before;
    fwd_seq[0] = 2'b10; fwd_seq[1] = 2'b11; fwd_seq[2] = 2'b01; fwd_seq[3] = 2'b00;
    rev_seq[0] = 2'b01; rev_seq[1] = 2'b11; rev_seq[2] = 2'b10; rev_seq[3] = 2'b00;

    rst = 1'b1; a_in = 0; b_in = 0; en = 1; clr_err = 0;
    #2;
    model_reset();
    check("reset.ready", 32'(bus8.ready), 0);
    check("reset.dir",   32'(bus8.dir),   1);
    check("reset.step",  32'(bus8.step),  0);
    check("reset.err",   32'(bus8.err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: ready after FILT_LEN+2 edges, then forward twice with latency check
    hold(FILT_LEN + 1);
    check("t1.ready_early", 32'(bus8.ready), 0);
    tick();
    check("t1.ready", 32'(bus8.ready), 1);
    hold(4);
    n_steps = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        {a_in, b_in} = fwd_seq[i];
        if (r == 0 && i == 0) begin
          hold(FILT_LEN + 2);
          check("t1.lat_early", 32'(bus8.step), 0);
          tick();
          check("t1.lat", 32'(bus8.step), 1);
          hold(13);
        end else begin
          hold(20);
        end
      end
    end
    check("t1.steps", 32'(n_steps), 8);
    check("t1.dir", 32'(bus8.dir), 1);
    check("t1.err", 32'(bus8.err_cnt), 0);

    // 2: reverse sequence, then one forward move
    n_steps = 0;
    for (int i = 0; i < 4; i++) begin
      drive(rev_seq[i], 20);
      if (i == 0) check("t2.dir_rev", 32'(bus8.dir), 0);
    end
    check("t2.steps_rev", 32'(n_steps), 4);
    n_steps = 0;
    drive(2'b10, 20);
    check("t2.dir_fwd", 32'(bus8.dir), 1);
    check("t2.steps_fwd", 32'(n_steps), 1);

    // 3: glitch shorter than FILT_LEN is absorbed; a long pulse is not
    drive(2'b00, 20);
    n_steps = 0;
    drive(2'b10, 3);
    drive(2'b00, 20);
    check("t3.glitch_steps", 32'(n_steps), 0);
    check("t3.glitch_ab", 32'(bus8.ab_state), 0);
    drive(2'b10, 10);
    hold(10);
    check("t3.long_steps", 32'(n_steps), 1);

    // 4: both bits at once is illegal
    drive(2'b00, 20);
    dir_before = bus8.dir;
    n_steps = 0; n_errp = 0;
    drive(2'b11, 20);
    check("t4.err_pulses", 32'(n_errp), 1);
    check("t4.err_cnt", 32'(bus8.err_cnt), 1);
    check("t4.steps", 32'(n_steps), 0);
    check("t4.dir", 32'(bus8.dir), 32'(dir_before));
    check("t4.ab", 32'(bus8.ab_state), 3);

    // 5: saturation of the 2-bit counter, clear coincident with an error
    clr_err = 1; tick(); clr_err = 0;
    for (int i = 0; i < 5; i++) drive((i % 2 == 0) ? 2'b00 : 2'b11, 20);
    check("t5.sat2", 32'(bus2.err_cnt), 3);
    check("t5.cnt8", 32'(bus8.err_cnt), 5);
    {a_in, b_in} = 2'b11;
    hold(FILT_LEN + 2);
    clr_err = 1;
    tick();
    clr_err = 0;
    check("t5.clr_pulse", 32'(bus8.err_pulse), 1);
    check("t5.clr_cnt8", 32'(bus8.err_cnt), 1);
    check("t5.clr_cnt2", 32'(bus2.err_cnt), 1);
    hold(10);

    // 6: resting at 11 through reset, en gating, mid-sequence reset
    do_reset(3);
    hold(FILT_LEN + 1);
    check("t6.ready_early", 32'(bus8.ready), 0);
    tick();
    check("t6.ready", 32'(bus8.ready), 1);
    check("t6.ab", 32'(bus8.ab_state), 3);
    check("t6.err", 32'(bus8.err_cnt), 0);
    en = 0; n_steps = 0;
    drive(2'b01, 20); drive(2'b00, 20); drive(2'b10, 20);
    check("t6.en_off", 32'(n_steps), 0);
    en = 1;
    drive(2'b11, 20);
    check("t6.en_on", 32'(n_steps), 1);
    {a_in, b_in} = 2'b01;
    hold(4);
    rst = 1'b1;
    #1;
    check("t6.rst_ready", 32'(bus8.ready), 0);
    check("t6.rst_ab", 32'(bus8.ab_state), 0);
    check("t6.rst_dir", 32'(bus8.dir), 1);
    check("t6.rst_step", 32'(bus8.step), 0);
    do_reset(2);

    // Random encoder activity with en / clr_err noise
    for (int s = 0; s < 300; s++) begin
      {a_in, b_in} = 2'($urandom_range(3));
      en = ($urandom_range(9) != 0);
      for (int c = 0; c < int'($urandom_range(12, 1)); c++) begin
        clr_err = ($urandom_range(15) == 0);
        tick();
      end
      clr_err = 0;
    end
    hold(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
